// File: rtl/rf_multiport.sv
// rf_multiport: multi-port register file with a hardware clear sequencer and two priority write ports.
// Same-cycle write-to-read forwarding is enabled by defining RF_MULTIPORT_BYPASS_EN.
module rf_multiport #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                busy,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic [AW-1:0]   LAST_IDX  = AW'(NREGS - 1);
  localparam logic [AW-1:0]   ZERO_ADDR = {AW{1'b0}};
  localparam logic [AW-1:0]   ONE_ADDR  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO_DATA = {XLEN{1'b0}};

  state_t          state_r;
  logic [AW-1:0]   ccnt_r;
  logic [XLEN-1:0] mem_r [NREGS];
  logic            wr0_s;
  logic            wr1_s;

  // Qualified write strobes: the clear sequencer owns the array while busy, and x0 never takes a write.
  assign wr0_s = we0 && !busy && (waddr0 != ZERO_ADDR);
  assign wr1_s = we1 && !busy && (waddr1 != ZERO_ADDR);

  // Clear sequencer: walks every index once after reset or a sampled clr_req, busy tracks CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLEAR;
      ccnt_r  <= ZERO_ADDR;
      busy    <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          ccnt_r <= ccnt_r + ONE_ADDR;
          if (ccnt_r == LAST_IDX) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= CLEAR;
            busy    <= 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state_r <= CLEAR;
            ccnt_r  <= ZERO_ADDR;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= CLEAR;
          ccnt_r  <= ZERO_ADDR;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  // Array update: port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_r[ccnt_r] <= ZERO_DATA;
    end else begin
      if (wr0_s) begin
        mem_r[waddr0] <= wdata0;
      end
      if (wr1_s) begin
        mem_r[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr_s;
    logic [XLEN-1:0] data_s;

    assign addr_s = raddr[k*AW +: AW];

    // Read mux: busy and x0 force zero; optional forwarding prefers port 1 over port 0.
    always_comb begin
      data_s = ZERO_DATA;
      if (busy || (addr_s == ZERO_ADDR)) begin
        data_s = ZERO_DATA;
`ifdef RF_MULTIPORT_BYPASS_EN
      end else if (wr1_s && (waddr1 == addr_s)) begin
        data_s = wdata1;
      end else if (wr0_s && (waddr0 == addr_s)) begin
        data_s = wdata0;
`endif
      end else begin
        data_s = mem_r[addr_s];
      end
    end

    assign rdata[k*XLEN +: XLEN] = data_s;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: a whole-array reference model predicts busy and every read port,
// a negedge monitor pops and compares. Honours RF_MULTIPORT_BYPASS_EN like the design.
module tb_rf_multiport;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic                clk;
  logic                rst;
  logic                clr_req;
  logic                busy;
  logic                we0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                we1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;

  rf_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: contents as seen after the clear, plus remaining clear edges
  logic [XLEN-1:0]     ref_mem [NREGS];
  int                  clear_left;
  logic                exp_busy_q [$];
  logic [NRD*XLEN-1:0] exp_rd_q [$];
  int                  tag_q [$];
  int                  errors = 0;
  int                  checks = 0;

  function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
    if (clear_left > 0) return 64'd0;
    if (a == 5'd0) return 64'd0;
`ifdef RF_MULTIPORT_BYPASS_EN
    if (we1 && (waddr1 == a) && (waddr1 != 5'd0)) return wdata1;
    if (we0 && (waddr0 == a) && (waddr0 != 5'd0)) return wdata0;
`endif
    return ref_mem[a];
  endfunction

  task automatic zero_model();
    for (int i = 0; i < NREGS; i++) ref_mem[i] = 64'd0;
  endtask

  // one clock cycle: drive inputs, push the prediction, advance the model over the edge
  task automatic step(input logic r, input logic c,
                      input logic w0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                      input logic w1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input int tag);
    rst = r; clr_req = c;
    we0 = w0; waddr0 = a0; wdata0 = d0;
    we1 = w1; waddr1 = a1; wdata1 = d1;
    raddr = {ra1, ra0};
    if (r) begin
      clear_left = NREGS;
      zero_model();
    end
    exp_busy_q.push_back(clear_left > 0);
    exp_rd_q.push_back({model_read(ra1), model_read(ra0)});
    tag_q.push_back(tag);
    @(posedge clk);
    if (!r) begin
      if (clear_left > 0) begin
        clear_left--;
      end else begin
        if (w0 && a0 != 5'd0) ref_mem[a0] = d0;
        if (w1 && a1 != 5'd0) ref_mem[a1] = d1;
        if (c) begin
          zero_model();
          clear_left = NREGS;
        end
      end
    end
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b, input int tag);
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, a, b, tag);
  endtask

  // monitor: one prediction per cycle, compared mid-cycle
  initial begin
    logic                eb;
    logic [NRD*XLEN-1:0] er;
    int                  tg;
    forever begin
      @(negedge clk);
      if (exp_busy_q.size() > 0) begin
        eb = exp_busy_q.pop_front();
        er = exp_rd_q.pop_front();
        tg = tag_q.pop_front();
        checks++;
        if (busy !== eb) begin
          errors++;
          $display("FAIL busy tag=%0d t=%0t got=%0b exp=%0b", tg, $time, busy, eb);
        end
        for (int k = 0; k < NRD; k++) begin
          checks++;
          if (rdata[k*XLEN +: XLEN] !== er[k*XLEN +: XLEN]) begin
            errors++;
            $display("FAIL rdata%0d tag=%0d t=%0t addr=%0d got=%h exp=%h", k, tg, $time,
                     raddr[k*AW +: AW], rdata[k*XLEN +: XLEN], er[k*XLEN +: XLEN]);
          end
        end
      end
    end
  end

  initial begin
    logic            r, c, w0, w1;
    logic [AW-1:0]   a0, a1, ra0, ra1;
    logic [XLEN-1:0] d0, d1;
    rst = 1'b1; clr_req = 1'b0;
    we0 = 1'b0; waddr0 = 5'd0; wdata0 = 64'd0;
    we1 = 1'b0; waddr1 = 5'd0; wdata1 = 64'd0;
    raddr = 10'd0;
    clear_left = NREGS;
    zero_model();
    @(posedge clk); #1;

    // reset and the following full clear, then sweep every address
    repeat (3) step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 1);
    for (int i = 0; i < 34; i++) rd(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), 2);
    for (int i = 0; i < 16; i++) rd(AW'(2 * i), AW'(2 * i + 1), 3);

    // basic write/read and x0 protection
    step(1'b0, 1'b0, 1'b1, 5'd5, 64'h1234_5678_9ABC_DEF0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd1, 4);
    rd(5'd5, 5'd5, 5);
    step(1'b0, 1'b0, 1'b1, 5'd0, 64'h0000_0000_0000_FFFF, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 6);
    rd(5'd0, 5'd0, 6);

    // collisions: same address then different addresses
    step(1'b0, 1'b0, 1'b1, 5'd7, 64'hAA, 1'b1, 5'd7, 64'hBB, 5'd6, 5'd8, 7);
    rd(5'd7, 5'd7, 8);
    step(1'b0, 1'b0, 1'b1, 5'd7, 64'hAA, 1'b1, 5'd8, 64'hBB, 5'd1, 5'd2, 9);
    rd(5'd7, 5'd8, 9);

    // fill, then clear with a concurrent write; writes and a second clr_req during busy
    for (int i = 1; i < NREGS; i++)
      step(1'b0, 1'b0, 1'b1, AW'(i), XLEN'(i), 1'b0, 5'd0, 64'd0, AW'(i - 1), AW'(i), 10);
    rd(5'd1, 5'd31, 11);
    step(1'b0, 1'b1, 1'b1, 5'd3, 64'h55, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4, 12);
    for (int i = 0; i < NREGS; i++)
      step(1'b0, (i == 12), (i == 5), 5'd4, 64'h99, (i == 5), 5'd10, 64'h98, 5'd3, 5'd4, 13);
    for (int i = 0; i < 16; i++) rd(AW'(2 * i), AW'(2 * i + 1), 14);

    // reset in the middle of a clear restarts the full sequence
    for (int i = 1; i < 6; i++)
      step(1'b0, 1'b0, 1'b1, AW'(i), XLEN'(64'hC0 + i), 1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 15);
    step(1'b0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 15);
    repeat (9) rd(5'd1, 5'd2, 15);
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 16);
    for (int i = 0; i < 34; i++) rd(AW'(i % 32), 5'd9, 17);

    // same-cycle write and read of r9
    step(1'b0, 1'b0, 1'b1, 5'd9, 64'h77, 1'b0, 5'd0, 64'd0, 5'd9, 5'd9, 18);
    rd(5'd9, 5'd9, 19);

    // randomized traffic with rare clears and resets
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      c   = ($urandom_range(0, 39) == 0);
      w0  = ($urandom_range(0, 2) != 0);
      w1  = ($urandom_range(0, 2) != 0);
      a0  = AW'($urandom_range(0, 31));
      a1  = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 31));
      d0  = {$urandom, $urandom};
      d1  = {$urandom, $urandom};
      ra0 = ($urandom_range(0, 1) == 0) ? a0 : AW'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 1) == 0) ? a1 : AW'($urandom_range(0, 31));
      step(r, c, w0, a0, d0, w1, a1, d1, ra0, ra1, 100);
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_busy_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_busy_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_busy_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised multi-port register file, the next generation of the core's integer register file. It provides configurable data width, register count and read-port count, and two write ports with fixed priority. A hardware clear sequencer zeroes the array after reset or on request. It sits between decode (read addresses) and writeback (write ports) in the datapath and serves both the single-cycle core and the planned dual-issue variant.

## Interface
Parameters:
- `XLEN`, 64, data width of each register.
- `NREGS`, 32, number of registers; power of two, minimum 4.
- `AW`, `$clog2(NREGS)`, address width; derived, not overridden.
- `NRD`, 2, number of combinational read ports, 1 to 4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr_req`  in  1  single-cycle pulse requesting a full clear.
- `busy`  out  1  clear sequence in progress.
- `we0`  in  1  write enable, port 0.
- `waddr0`  in  AW  write address, port 0.
- `wdata0`  in  XLEN  write data, port 0.
- `we1`  in  1  write enable, port 1; has priority over port 0.
- `waddr1`  in  AW  write address, port 1.
- `wdata1`  in  XLEN  write data, port 1.
- `raddr`  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- `rdata`  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].

## Operation
- Register 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
- FSM has two states, `CLEAR` and `IDLE`, with an AW-bit clear counter `ccnt`.
- `rst` asserted:
  - Asynchronously sets state = `CLEAR`, `ccnt` = 0, `busy` = 1.
  - Array contents are not reset directly; the clear sequence zeroes them.
- `CLEAR`, each rising edge:
  - Writes 0 to the register at index `ccnt`, then increments `ccnt`.
  - When `ccnt == NREGS-1`, the edge writes the last register and moves the FSM to `IDLE`.
- `IDLE` with `clr_req` = 1: moves to `CLEAR` with `ccnt` = 0.
- `IDLE` with `clr_req` = 0: stays in `IDLE`.
- `clr_req` while in `CLEAR` is ignored; the sequence does not restart.
- `busy` = 1 exactly when state = `CLEAR`. It is a registered output with no combinational path from inputs.
- While `busy` = 1:
  - `we0` and `we1` are ignored; the writes are dropped, not queued.
  - All `rdata` ports return 0.
- Writes in `IDLE`:
  - Each port with `weN` = 1 and `waddrN` != 0 writes `wdataN` at the rising edge.
  - If both ports target the same nonzero address, port 1's data is stored.
  - Writes to different addresses both commit.
- A write in the same `IDLE` cycle that `clr_req` is sampled still commits. The following clear then zeroes it.
- Reads are combinational from the array for every port independently. Any number of ports may read the same address.

## Timing
- Read latency: 0 cycles (combinational).
- Write-to-read visibility without bypass: 1 cycle, i.e. the value is visible after the committing edge.
- Clear duration: `busy` is high for exactly NREGS rising edges after `rst` deasserts, or after the edge that samples `clr_req`.
  - The first edge with `busy` = 0 accepts writes.
- `rst` asserted mid-clear: the sequence restarts from `ccnt` = 0 and runs the full NREGS cycles again.
- `rst` asserted mid-write: the write is lost and the register holds its previous value until the clear zeroes it.
- `busy` rises on the edge after `clr_req` is sampled. During the cycle in which `clr_req` is high, `busy` is still 0.

## Configuration
- Macro: `RF_MULTIPORT_BYPASS_EN`.
- Defined: each read port compares its address against both write ports in the same cycle. The forwarding condition is:
  - `weN` = 1,
  - `busy` = 0,
  - the address is nonzero,
  - and the address matches.
- When the condition holds, the port returns that `wdataN`. If both write ports match, port 1 wins.
- Not defined: no forwarding; reads always return the array contents before the edge.
- Array update behaviour is identical in both builds.

## Test plan
- Reset clear: pulse `rst`, then release. Required:
  - `busy` = 1 for exactly 32 edges (default NREGS), then 0.
  - Every `rdata` = 0 throughout.
  - Reading all 32 addresses afterwards returns 0.
- Basic write/read, x0 protection:
  - Write 0x1234_5678_9ABC_DEF0 to r5 via port 0, then read r5 on port 0 and port 1 → both 0x1234_5678_9ABC_DEF0.
  - Write 0xFFFF to r0 → reading r0 returns 0.
- Write collision: `we0` = `we1` = 1, both to r7, `wdata0` = 0xAA, `wdata1` = 0xBB → r7 reads 0xBB next cycle.
  - Same cycle with r7/r8: r7 = 0xAA, r8 = 0xBB.
- Clear during operation:
  - Fill r1..r31 with index values, pulse `clr_req` together with a write of 0x55 to r3. Required: `busy` high for 32 edges, then all reads return 0.
  - Writes issued while `busy` is high are dropped; the target register reads 0 afterwards.
  - `clr_req` pulsed mid-clear does not extend `busy`.
- Reset mid-clear plus bypass:
  - Assert `rst` at edge 10 of a clear → `busy` is high for 32 edges after release.
  - With `RF_MULTIPORT_BYPASS_EN`, write 0x77 to r9 while reading r9 in the same cycle → `rdata` = 0x77.
  - Without the macro, the same stimulus returns the old value (0), and 0x77 appears the next cycle.
